// File: rtl/gb_serial_link.sv
// Game Boy link-port serial unit (SB/SC). It shifts 8 bits MSB-first as the clock master
// on an internal shift clock, or as the slave on the partner's synchronised clock.
module gb_serial_link #(
    parameter int HALF_PERIOD = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_sel_sb,
    input  logic       cpu_sel_sc,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    output logic       irq,
    input  logic       ser_clk_in,
    input  logic       ser_in,
    output logic       ser_clk_out,
    output logic       ser_clk_oe,
    output logic       ser_out
);

    localparam int              PH_W    = $clog2(HALF_PERIOD);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MASTER = 2'd1;
    localparam logic [1:0] ST_SLAVE  = 2'd2;

    logic [7:0]      sb_q, sb_d;
    logic            start_q, start_d;
    logic            clk_sel_q, clk_sel_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic            clk_out_q, clk_out_d;
    logic            ser_out_q, ser_out_d;
    logic            irq_q, irq_d;
    logic            clk_s1_q, clk_s2_q, clk_s3_q;
    logic            din_s1_q, din_s2_q;

    logic [1:0] state;
    logic       tick;
    logic       fall;
    logic       rise;
    logic       wr_sb;
    logic       wr_sc;

    assign wr_sb = cpu_wr && cpu_sel_sb;
    assign wr_sc = cpu_wr && cpu_sel_sc;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state     = !start_q ? ST_IDLE : (clk_sel_q ? ST_MASTER : ST_SLAVE);
        tick      = (ph_q == PH_LAST);
        fall      = 1'b0;
        rise      = 1'b0;
        sb_d      = sb_q;
        start_d   = start_q;
        clk_sel_d = clk_sel_q;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        clk_out_d = clk_out_q;
        ser_out_d = ser_out_q;
        irq_d     = 1'b0;

        case (state)
            ST_MASTER: begin
                ph_d = tick ? '0 : ph_q + PH_W'(1);
                if (tick) begin
                    clk_out_d = ~clk_out_q;
                    fall      = clk_out_q;
                    rise      = ~clk_out_q;
                end
            end
            ST_SLAVE: begin
                fall = clk_s3_q & ~clk_s2_q;
                rise = ~clk_s3_q & clk_s2_q;
            end
            default: ;
        endcase

        if (fall) begin
            ser_out_d = sb_q[7];
        end
        if (rise) begin
            sb_d  = {sb_q[6:0], din_s2_q};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                start_d = 1'b0;
                irq_d   = 1'b1;
            end
        end

        if (wr_sb && !start_q) begin
            sb_d = cpu_di;
        end

        // An SC write overrides everything this cycle, including a coincident completion.
        if (wr_sc) begin
            sb_d      = sb_q;
            clk_sel_d = cpu_di[0];
            start_d   = cpu_di[7];
            cnt_d     = 3'd0;
            ph_d      = '0;
            clk_out_d = 1'b1;
            irq_d     = 1'b0;
            ser_out_d = cpu_di[7] ? sb_q[7] : ser_out_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q      <= 8'h00;
            start_q   <= 1'b0;
            clk_sel_q <= 1'b0;
            cnt_q     <= 3'd0;
            ph_q      <= '0;
            clk_out_q <= 1'b1;
            ser_out_q <= 1'b1;
            irq_q     <= 1'b0;
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_s3_q  <= 1'b1;
            din_s1_q  <= 1'b1;
            din_s2_q  <= 1'b1;
        end else begin
            sb_q      <= sb_d;
            start_q   <= start_d;
            clk_sel_q <= clk_sel_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            clk_out_q <= clk_out_d;
            ser_out_q <= ser_out_d;
            irq_q     <= irq_d;
            clk_s1_q  <= ser_clk_in;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            din_s1_q  <= ser_in;
            din_s2_q  <= din_s1_q;
        end
    end

    always_comb begin
        if (cpu_sel_sb) begin
            cpu_do = sb_q;
        end else if (cpu_sel_sc) begin
            cpu_do = {start_q, 6'h3F, clk_sel_q};
        end else begin
            cpu_do = 8'hFF;
        end
    end

    assign irq         = irq_q;
    assign ser_clk_out = clk_out_q;
    assign ser_clk_oe  = clk_sel_q;
    assign ser_out     = ser_out_q;

endmodule

// File: tb/tb_gb_serial_link.sv
// Directed bench for gb_serial_link: reset, master loopback, slave, idle, abort/restart, collisions.
module tb_gb_serial_link;

    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_sel_sb;
    logic       cpu_sel_sc;
    logic       cpu_wr;
    logic [7:0] cpu_di;
    logic [7:0] cpu_do;
    logic       irq;
    logic       ser_clk_in;
    logic       ser_in;
    logic       ser_in_drv;
    logic       ser_clk_out;
    logic       ser_clk_oe;
    logic       ser_out;
    logic       loop_en;

    gb_serial_link #(.HALF_PERIOD(HP)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_sel_sb  (cpu_sel_sb),
        .cpu_sel_sc  (cpu_sel_sc),
        .cpu_wr      (cpu_wr),
        .cpu_di      (cpu_di),
        .cpu_do      (cpu_do),
        .irq         (irq),
        .ser_clk_in  (ser_clk_in),
        .ser_in      (ser_in),
        .ser_clk_out (ser_clk_out),
        .ser_clk_oe  (ser_clk_oe),
        .ser_out     (ser_out)
    );

    assign ser_in = loop_en ? ser_out : ser_in_drv;

    always #5 clk = ~clk;

    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         irq_count = 0;
    int         irq_cyc   = 0;
    int         cap_n     = 0;
    logic       prev_sco  = 1'b1;
    logic [7:0] out_cap   = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Counts irq-high cycles and records ser_out at every rising edge of the internal shift clock.
    always @(negedge clk) begin
        if (irq) begin
            irq_count = irq_count + 1;
            irq_cyc   = cyc;
        end
        if (!prev_sco && ser_clk_out) begin
            out_cap = {out_cap[6:0], ser_out};
            cap_n   = cap_n + 1;
        end
        prev_sco = ser_clk_out;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic to_sb, input logic [7:0] d);
        cpu_sel_sb = to_sb;
        cpu_sel_sc = ~to_sb;
        cpu_wr     = 1'b1;
        cpu_di     = d;
        step(1);
        cpu_wr     = 1'b0;
        cpu_sel_sb = 1'b0;
        cpu_sel_sc = 1'b0;
    endtask

    task automatic cpu_read(input logic from_sb, output logic [7:0] d);
        cpu_sel_sb = from_sb;
        cpu_sel_sc = ~from_sb;
        #1;
        d          = cpu_do;
        cpu_sel_sb = 1'b0;
        cpu_sel_sc = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] pat;
        logic [7:0] slv_cap;
        int         t0;
        int         t_r;
        int         ic0;

        reset      = 1'b1;
        cpu_sel_sb = 1'b0;
        cpu_sel_sc = 1'b0;
        cpu_wr     = 1'b0;
        cpu_di     = 8'h00;
        ser_clk_in = 1'b1;
        ser_in_drv = 1'b1;
        loop_en    = 1'b1;
        #12;
        check("rst_irq", irq, 1'b0);
        check("rst_sco", ser_clk_out, 1'b1);
        check("rst_ser_out", ser_out, 1'b1);
        check("rst_oe", ser_clk_oe, 1'b0);
        cpu_read(1'b0, rd);
        check("rst_sc", rd, 8'h7E);
        cpu_read(1'b1, rd);
        check("rst_sb", rd, 8'h00);
        step(1);
        reset = 1'b0;
        step(2);

        // Master loopback of 8'hA5
        cpu_write(1'b1, 8'hA5);
        cpu_write(1'b0, 8'h81);
        t0    = cyc;
        ic0   = irq_count;
        cap_n = 0;
        check("m_oe", ser_clk_oe, 1'b1);
        check("m_first_bit", ser_out, 1'b1);
        step(HP - 1);
        check("m_sco_before_fall", ser_clk_out, 1'b1);
        step(1);
        check("m_first_fall", ser_clk_out, 1'b0);
        step(16 * HP - HP);
        check("m_irq_now", irq, 1'b1);
        step(5);
        check("m_irq_count", irq_count - ic0, 1);
        check("m_irq_time", irq_cyc - t0, 16 * HP);
        check("m_bits", out_cap, 8'hA5);
        check("m_nbits", cap_n, 8);
        cpu_read(1'b1, rd);
        check("m_sb", rd, 8'hA5);
        cpu_read(1'b0, rd);
        check("m_sc", rd, 8'h7F);

        // Reset asserted mid-transfer
        cpu_write(1'b0, 8'h81);
        ic0 = irq_count;
        step(20);
        #2;
        reset = 1'b1;
        #1;
        check("mr_irq", irq, 1'b0);
        check("mr_sco", ser_clk_out, 1'b1);
        check("mr_ser_out", ser_out, 1'b1);
        cpu_read(1'b0, rd);
        check("mr_sc", rd, 8'h7E);
        cpu_read(1'b1, rd);
        check("mr_sb", rd, 8'h00);
        step(1);
        reset = 1'b0;
        step(80);
        check("mr_no_irq", irq_count - ic0, 0);

        // Slave: send 8'h3C while receiving 8'hC3
        loop_en = 1'b0;
        cpu_write(1'b1, 8'h3C);
        cpu_write(1'b0, 8'h80);
        ic0     = irq_count;
        pat     = 8'hC3;
        slv_cap = 8'h00;
        t_r     = 0;
        for (int i = 0; i < 8; i++) begin
            ser_clk_in = 1'b0;
            ser_in_drv = pat[7 - i];
            step(6);
            ser_clk_in = 1'b1;
            slv_cap    = {slv_cap[6:0], ser_out};
            t_r        = cyc;
            step(6);
        end
        check("s_sco_idle", ser_clk_out, 1'b1);
        check("s_bits", slv_cap, 8'h3C);
        check("s_irq_count", irq_count - ic0, 1);
        check("s_irq_latency", irq_cyc - t_r, 3);
        cpu_read(1'b1, rd);
        check("s_sb", rd, 8'hC3);
        cpu_read(1'b0, rd);
        check("s_sc", rd, 8'h7E);

        // Idle: partner clock edges must have no effect
        ic0 = irq_count;
        for (int i = 0; i < 20; i++) begin
            ser_clk_in = ~ser_clk_in;
            ser_in_drv = 1'($urandom);
            step(5);
        end
        cpu_read(1'b1, rd);
        check("i_sb", rd, 8'hC3);
        check("i_no_irq", irq_count - ic0, 0);

        // Abort after 3 bits, then restart
        loop_en = 1'b1;
        cpu_write(1'b1, 8'hA5);
        cpu_write(1'b0, 8'h81);
        ic0 = irq_count;
        step(26);
        cpu_write(1'b0, 8'h01);
        step(2);
        check("a_sco", ser_clk_out, 1'b1);
        cpu_read(1'b0, rd);
        check("a_sc", rd, 8'h7F);
        cpu_read(1'b1, rd);
        check("a_sb_partial", rd, 8'h2D);
        step(80);
        check("a_no_irq", irq_count - ic0, 0);

        cpu_write(1'b0, 8'h81);
        t0    = cyc;
        ic0   = irq_count;
        cap_n = 0;
        step(10);
        cpu_write(1'b1, 8'h00);
        step(16 * HP - 5);
        check("r_irq_count", irq_count - ic0, 1);
        check("r_irq_time", irq_cyc - t0, 16 * HP);
        check("r_bits", out_cap, 8'h2D);
        check("r_nbits", cap_n, 8);
        cpu_read(1'b1, rd);
        check("r_sb_write_ignored", rd, 8'h2D);

        // SC write on the same edge as the 8th rise
        cpu_write(1'b0, 8'h81);
        ic0 = irq_count;
        step(16 * HP - 1);
        cpu_write(1'b0, 8'h81);
        t0 = cyc;
        step(3);
        check("c_no_irq", irq_count - ic0, 0);
        cpu_read(1'b0, rd);
        check("c_sc_running", rd, 8'hFF);
        step(16 * HP + 6);
        check("c_irq_count", irq_count - ic0, 1);
        check("c_irq_time", irq_cyc - t0, 16 * HP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gb_serial_link.md
# gb_serial_link

Full Game Boy link-port serial unit (SB at $FF01, SC at $FF02) that replaces the dummy serial stub in the `gb` top level. It runs as clock master (internal 8192 Hz shift clock) or as the responding end of the link cable (shift clock driven by the partner). It shifts 8 bits MSB-first between SB and the link pins. It raises a one-clock serial interrupt pulse on completion, which feeds IF bit 3.

## Interface
- HALF_PERIOD, 256, `clk` cycles per half shift-clock period in internal mode (256 → 8192 Hz at 4.194304 MHz); must be ≥ 2
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_sel_sb  in  1  CPU address decodes $FF01
- cpu_sel_sc  in  1  CPU address decodes $FF02
- cpu_wr  in  1  CPU write strobe (active high), qualified by the selects
- cpu_di  in  8  CPU write data
- cpu_do  out  8  read data, combinational: sel_sb → SB; sel_sc → {start, 6'h3F, clk_sel}; else 8'hFF
- irq  out  1  one-clock pulse on transfer completion
- ser_clk_in  in  1  shift clock from partner (asynchronous)
- ser_in  in  1  serial data from partner (asynchronous)
- ser_clk_out  out  1  internal shift clock; idles high
- ser_clk_oe  out  1  equals clk_sel; high when this end drives the clock
- ser_out  out  1  serial data to partner

## Operation
- Registers: sb[7:0], start, clk_sel, bit counter cnt[2:0], phase counter ph (enough bits for HALF_PERIOD-1), sync flops clk_s1/clk_s2/clk_s3 and din_s1/din_s2.
- Reset values: sb=8'h00, start=0, clk_sel=0, cnt=0, ph=0, ser_clk_out=1, ser_out=1, irq=0, all sync flops=1.
- SB write when start=0: sb ← cpu_di. SB write when start=1: ignored.
- SC write: clk_sel ← cpu_di[0]; start ← cpu_di[7]; cnt ← 0; ph ← 0; ser_clk_out ← 1.
  - If cpu_di[7]=1: ser_out ← sb[7]. A running transfer restarts from bit 0 with the current sb.
  - If cpu_di[7]=0: the running transfer aborts with no irq; sb keeps its partial contents.
- States: IDLE (start=0), MASTER (start=1, clk_sel=1), SLAVE (start=1, clk_sel=0).
- A shift-clock falling edge (fall) drives ser_out ← sb[7].
- A shift-clock rising edge (rise) does sb ← {sb[6:0], sample}, then cnt ← cnt+1.
- On the 8th rise (cnt==7):
  - start ← 0 and irq ← 1 for one cycle.
  - cnt wraps to 0.
  - ser_out holds its value.
- MASTER:
  - ph counts 0..HALF_PERIOD-1. At terminal count, ph ← 0 and ser_clk_out toggles.
  - The first toggle after start is 1→0 (fall).
  - Sample = din_s2.
- SLAVE:
  - ser_clk_out stays 1.
  - ser_clk_in passes through a 2-flop synchronizer; clk_s3 is the previous value.
  - fall = clk_s3 & ~clk_s2; rise = ~clk_s3 & clk_s2; sample = din_s2.
  - Edges in IDLE or MASTER are ignored; the sync flops always run.
- Changing clk_sel is only possible through an SC write, which restarts the transfer.

## Timing
- Internal-mode SC write with start=1 at edge T:
  - ser_out=sb[7] from T+1.
  - First fall of ser_clk_out at T+HALF_PERIOD.
  - k-th rise at T+(2k)·HALF_PERIOD, with the sample taken at that edge.
  - The 8th rise is at T+16·HALF_PERIOD (4096 cycles at default).
  - irq is high for exactly the one cycle after the 8th rise; start reads 0 from the same cycle.
- External mode: latency from a ser_clk_in pin edge to the resulting ser_out/sb update is 3 clk edges. The partner's half period must be ≥ 4 clk cycles.
- Simultaneous events:
  - SC write in the same cycle as the 8th rise: the write wins, completion is discarded, no irq.
  - SB write in the same cycle as completion: ignored, because start was 1 at that edge.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous); no irq.
- cpu_do is purely combinational from the selects and registers; zero latency.

## Test plan
- Reset: assert reset mid-transfer → irq=0, ser_clk_out=1, ser_out=1, SC reads 8'h7E, SB reads 8'h00.
- Master loopback (ser_in tied to ser_out, HALF_PERIOD=4): write SB=8'hA5, then SC=8'h81 → ser_out sequence 1,0,1,0,0,1,0,1; irq pulses exactly once, 64 cycles after the SC write; SB reads 8'hA5; SC reads 8'h7F.
- Slave: write SB=8'h3C, SC=8'h80; bench drives 8 ser_clk_in cycles with ser_in bits of 8'hC3 (half period 6 clk) → ser_out shows 8'h3C MSB-first, SB=8'hC3, one irq pulse 3 clk after the last rising edge.
- Idle slave: with start=0, toggle ser_clk_in 20 times → SB unchanged, no irq.
- Abort/restart: in master mode, write SC=8'h01 after 3 bits → no irq, ser_clk_out=1, start=0. Then write SC=8'h81 → full 16·HALF_PERIOD transfer from bit 0.
- Collisions:
  - SB write during an active transfer is ignored.
  - SC write coinciding with the 8th rise → no irq, new transfer begins.
